// File: rtl/vx_mem_perf_ctr.sv
// Memory performance counters.
// Passively observes a memory request/response handshake and reports the
// accepted read and write requests, the number of outstanding reads, and a
// latency integral (the sum over cycles of the outstanding-read count).
// Tracker overflow and underflow set a sticky error flag. All outputs are
// registered, so an event in cycle N is visible on the outputs in cycle N+1.

module vx_mem_perf_ctr #(
    parameter int unsigned PERF_CTR_BITS = 44,
    parameter int unsigned PENDING_BITS  = 8
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic                     perf_enable,
    input  logic                     perf_clear,

    input  logic                     mem_req_valid,
    input  logic                     mem_req_rw,
    input  logic                     mem_req_ready,
    input  logic                     mem_rsp_valid,
    input  logic                     mem_rsp_ready,

    output logic [PERF_CTR_BITS-1:0] mem_reads,
    output logic [PERF_CTR_BITS-1:0] mem_writes,
    output logic [PERF_CTR_BITS-1:0] mem_latency,
    output logic [PENDING_BITS-1:0]  pending_reads,
    output logic                     perf_error
);

    localparam logic [PENDING_BITS-1:0] PendingMax  = {PENDING_BITS{1'b1}};
    localparam logic [PENDING_BITS-1:0] PendingZero = '0;

    // Handshake decode; nothing here ever feeds back into the bus.
    logic read_fire;
    logic write_fire;
    logic rsp_fire;

    assign read_fire  = mem_req_valid & mem_req_ready & ~mem_req_rw;
    assign write_fire = mem_req_valid & mem_req_ready &  mem_req_rw;
    assign rsp_fire   = mem_rsp_valid & mem_rsp_ready;

    // Register state
    logic [PERF_CTR_BITS-1:0] mem_reads_q,   mem_reads_d;
    logic [PERF_CTR_BITS-1:0] mem_writes_q,  mem_writes_d;
    logic [PERF_CTR_BITS-1:0] mem_latency_q, mem_latency_d;
    logic [PENDING_BITS-1:0]  pending_q,     pending_d;
    logic                     error_q,       error_d;

    logic                     tracker_overflow;
    logic                     tracker_underflow;

    // Outstanding-read tracker: saturates at both ends instead of wrapping.
    // It runs regardless of perf_enable/perf_clear so it always mirrors the
    // true number of reads in flight.
    always_comb begin
        pending_d         = pending_q;
        tracker_overflow  = 1'b0;
        tracker_underflow = 1'b0;
        if (read_fire && !rsp_fire) begin
            if (pending_q == PendingMax) begin
                tracker_overflow = 1'b1;
            end else begin
                pending_d = pending_q + 1'b1;
            end
        end else if (rsp_fire && !read_fire) begin
            if (pending_q == PendingZero) begin
                tracker_underflow = 1'b1;
            end else begin
                pending_d = pending_q - 1'b1;
            end
        end
    end

    // Sticky error flag; clear wins over a set in the same cycle.
    always_comb begin
        error_d = error_q;
        if (perf_clear) begin
            error_d = 1'b0;
        end else if (tracker_overflow || tracker_underflow) begin
            error_d = 1'b1;
        end
    end

    // Event counters: modulo arithmetic, wrap is silent. Latency integrates
    // the tracker value as it stood during this cycle (before update).
    always_comb begin
        mem_reads_d   = mem_reads_q;
        mem_writes_d  = mem_writes_q;
        mem_latency_d = mem_latency_q;
        if (perf_clear) begin
            mem_reads_d   = '0;
            mem_writes_d  = '0;
            mem_latency_d = '0;
        end else if (perf_enable) begin
            mem_reads_d   = mem_reads_q   + PERF_CTR_BITS'(read_fire);
            mem_writes_d  = mem_writes_q  + PERF_CTR_BITS'(write_fire);
            mem_latency_d = mem_latency_q + PERF_CTR_BITS'(pending_q);
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_reads_q   <= '0;
            mem_writes_q  <= '0;
            mem_latency_q <= '0;
            pending_q     <= '0;
            error_q       <= 1'b0;
        end else begin
            mem_reads_q   <= mem_reads_d;
            mem_writes_q  <= mem_writes_d;
            mem_latency_q <= mem_latency_d;
            pending_q     <= pending_d;
            error_q       <= error_d;
        end
    end

    assign mem_reads     = mem_reads_q;
    assign mem_writes    = mem_writes_q;
    assign mem_latency   = mem_latency_q;
    assign pending_reads = pending_q;
    assign perf_error    = error_q;

endmodule

// File: doc/vx_mem_perf_ctr.md
VX_MEM_PERF_CTR -- requirements
Module: VX_mem_perf_ctr

Interface
REQ-001 The block SHALL have parameter PERF_CTR_BITS, default 44, the width of every performance counter output.
REQ-002 The block SHALL have parameter PENDING_BITS, default 8, the width of the outstanding-read tracker.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 perf_enable  in  1  1 = counters accumulate, 0 = counters hold.
REQ-007 perf_clear  in  1  synchronous clear of counters and error flag.
REQ-008 mem_req_valid  in  1  memory request valid.
REQ-009 mem_req_rw  in  1  request type: 1 = write, 0 = read.
REQ-010 mem_req_ready  in  1  memory request accepted by downstream.
REQ-011 mem_rsp_valid  in  1  memory read response valid.
REQ-012 mem_rsp_ready  in  1  memory read response consumed.
REQ-013 mem_reads  out  PERF_CTR_BITS  accepted read requests.
REQ-014 mem_writes  out  PERF_CTR_BITS  accepted write requests.
REQ-015 mem_latency  out  PERF_CTR_BITS  sum over cycles of outstanding reads.
REQ-016 pending_reads  out  PENDING_BITS  current outstanding reads.
REQ-017 perf_error  out  1  sticky tracker overflow/underflow flag.

Function
REQ-018 The block SHALL define read_fire = mem_req_valid & mem_req_ready & ~mem_req_rw, write_fire = mem_req_valid & mem_req_ready & mem_req_rw, and rsp_fire = mem_rsp_valid & mem_rsp_ready.
REQ-019 The block SHALL never drive or gate any handshake signal; it is a passive observer.
REQ-020 All outputs SHALL be registered; an event in cycle N SHALL be visible on the outputs in cycle N+1.
REQ-021 pending_reads SHALL increment by 1 on read_fire alone, decrement by 1 on rsp_fire alone, and hold on both or neither, independent of perf_enable and perf_clear.
REQ-022 On read_fire alone with pending_reads = 2^PENDING_BITS-1, pending_reads SHALL hold and perf_error SHALL set.
REQ-023 On rsp_fire alone with pending_reads = 0, pending_reads SHALL hold at 0 and perf_error SHALL set.
REQ-024 When perf_enable = 1 and perf_clear = 0: mem_reads += read_fire; mem_writes += write_fire; mem_latency += zero-extended pending_reads value of the current cycle (before update).
REQ-025 Counter arithmetic SHALL be modulo 2^PERF_CTR_BITS; wrap-around from all-ones to 0 SHALL be silent and SHALL NOT set perf_error.
REQ-026 When perf_enable = 0 and perf_clear = 0, mem_reads, mem_writes, and mem_latency SHALL hold.
REQ-027 perf_clear = 1 SHALL load 0 into mem_reads, mem_writes, mem_latency, and perf_error next cycle, overriding increments and error sets in that cycle; pending_reads SHALL NOT be cleared.
REQ-028 perf_error, once set, SHALL remain 1 until reset or perf_clear.

Reset
REQ-029 Asserting reset SHALL immediately force mem_reads, mem_writes, mem_latency, pending_reads, and perf_error to 0, including mid-transaction; events in cycles where reset is high SHALL be ignored.
REQ-030 After reset deasserts, the first rising edge SHALL process events normally.

Verification
REQ-031 Reset, enable=1, 3 read_fires in consecutive cycles, no rsp, then idle 2 cycles -> mem_reads=3, pending_reads=3, mem_latency=0+1+2+3+3=9.
REQ-032 read_fire and rsp_fire in the same cycle with pending_reads=2 -> pending_reads stays 2, mem_reads +1, mem_latency +2.
REQ-033 rsp_fire with pending_reads=0 -> pending_reads=0, perf_error=1, still 1 after 10 idle cycles; perf_clear pulse -> perf_error=0, pending_reads unchanged.
REQ-034 PENDING_BITS=2, 4 read_fires without rsp -> pending_reads=3, perf_error=1; mem_reads=4.
REQ-035 Preload mem_writes to 2^PERF_CTR_BITS-1 via stimulus (small PERF_CTR_BITS=4, 15 writes), 1 more write_fire -> mem_writes=0, perf_error=0.
REQ-036 enable=0 with 5 read_fires and 2 write_fires -> counters unchanged, pending_reads=5; assert reset mid-stream -> all outputs 0 asynchronously.
